regfile_ctrl: RTL and testbench
===============================

# regfile_ctrl

Access controller for the dual-port `reg_file`, on a single clock. After reset it zero-clears every entry, then shares the two ports between the core pipeline and the hardware accelerator. The core owns port A and the accelerator owns port B. Same-address write collisions are resolved with a fair round-robin, and architectural x0 semantics are enforced.

## Interface
- `DWIDTH`, 64, data width; matches `reg_file`.
- `AWIDTH`, 5, address width.
- `DEPTH`, 2**AWIDTH, entry count; must be even.
- `ZERO_REG`, 1, when 1, entry 0 is hardwired to zero (writes dropped, reads return 0).
- `clk` in 1: single clock; drives both `clka` and `clkb` of `reg_file`.
- `rst_n` in 1: reset, synchronous, active-low.
- `core_req` in 1: core access request.
- `core_we` in 1: 1 = write, 0 = read.
- `core_addr` in AWIDTH: core address.
- `core_wdata` in DWIDTH: core write data.
- `core_gnt` out 1: request accepted this cycle.
- `core_rvalid` out 1: `core_rdata` valid.
- `core_rdata` out DWIDTH: read data.
- `acc_req`, `acc_we`, `acc_addr`, `acc_wdata`, `acc_gnt`, `acc_rvalid`, `acc_rdata`: accelerator copies of the core ports, same directions and widths.
- `rf_wea` out 1, `rf_addra` out AWIDTH, `rf_dina` out DWIDTH, `rf_douta` in DWIDTH: port A of `reg_file`.
- `rf_web` out 1, `rf_addrb` out AWIDTH, `rf_dinb` out DWIDTH, `rf_doutb` in DWIDTH: port B of `reg_file`.
- `init_done` out 1: clear finished; accesses are accepted only while this is high.

## Operation
- States are CLEAR and RUN.
  - `rst_n` low at a clock edge sets state to CLEAR.
  - `rst_n` low also clears the clear counter `cnt`, `rvalid` (both), the zero-read flags and `init_done`, and sets `prio` to CORE.
- While `rst_n` is low, all `gnt` and `rf_we*` outputs are forced to 0 combinationally.
- CLEAR, each cycle:
  - Drive `rf_wea`=`rf_web`=1, `rf_addra`=`cnt`, `rf_addrb`=`cnt`+DEPTH/2, `rf_dina`=`rf_dinb`=0.
  - `cnt` increments each cycle.
  - When `cnt`==DEPTH/2-1, go to RUN the next cycle.
  - Both `gnt` outputs stay 0. Requests are ignored, not queued.
- RUN:
  - Core traffic is mapped to port A and accelerator traffic to port B.
  - `gnt` = `req`, except in the two cases below.
- Write collision: both requesters issue `req`=1, `we`=1 to the same address.
  - The requester named by `prio` is granted; the other gets `gnt`=0 and must hold its request.
  - `prio` flips to the loser at the clock edge.
  - No other event changes `prio`.
- Zero register: when `ZERO_REG`=1, a granted write to address 0 is granted but drives `rf_we*`=0.
  - A granted read of address 0 sets a registered flag that forces `rdata` to 0 in the following cycle.
- Read/write to the same address on the two ports in the same cycle is not a collision. Both are granted, and the read returns the old value (read-first).
- `rf_din*`, `rf_addr*` and `rf_we*` are combinational from the granted request.
- `rvalid` is set at the clock edge after a granted read (`req`&&`gnt`&&!`we`). It is a single-cycle pulse per read.
- `rdata` is a combinational pass-through of `rf_dout*`, masked by the zero flag.
- `rdata` is don't-care when `rvalid`=0.
- Reset mid-operation:
  - Any in-flight `rvalid` is dropped.
  - The full clear reruns.
  - A write granted in the reset cycle is not performed.

## Timing
- Read latency is 1 cycle: grant in cycle N, `rvalid`/`rdata` in cycle N+1.
- Write latency: committed at the end of the grant cycle; readable by a request in cycle N+1.
- Grant is combinational, zero-cycle from `req`. There is no flow-through from `gnt` back to `req`.
- Clear takes DEPTH/2 cycles: 16 for the defaults.
  - The first cycle with `rst_n` high is CLEAR with `cnt`=0.
  - `init_done`=1 from cycle DEPTH/2 onward (cycle 16), and the first grant can occur in that cycle.
- `init_done` is registered. It stays 1 until the next reset.
- Back-to-back requests are accepted every cycle with no bubbles.

## Structure
- Shared package `regfile_pkg`:
  - state encoding: ST_CLEAR, ST_RUN.
  - requester id constants: REQ_CORE=0, REQ_ACC=1.
  - `ZERO_ADDR` constant.
- One sub-module, `rf_wr_arb`, holds the collision detect, the `prio` flop and the grant generation.
- The top level holds the FSM, the clear counter, the port muxing, and the rvalid/zero-flag registers.

## Test plan
- Reset, then idle with `rst_n` high:
  - `rf_wea`/`rf_web` high for exactly 16 cycles, covering addresses 0-15 on port A and 16-31 on port B.
  - `init_done` rises in cycle 16, and `core_req` held during CLEAR sees `gnt`=0.
- Core writes 0xDEAD_BEEF to address 5, then reads address 5 in the next cycle:
  - `core_rvalid` one cycle after the read grant, with `core_rdata`=0xDEAD_BEEF.
- Both requesters write address 7 for 3 consecutive cycles, with core data 0x1 and accelerator data 0x2:
  - Grants go core, then acc, then core.
  - A final read of address 7 returns 0x1.
  - `prio` ends at ACC.
- With `ZERO_REG`=1, the core writes 0xFFFF to address 0 and the accelerator reads address 0:
  - `rf_wea`=0 and `core_gnt`=1.
  - A subsequent read of address 0 returns 0 with `rvalid` set.
- Core writes address 9 = 0x55 while the accelerator reads address 9 in the same cycle (old value 0x0):
  - `acc_rdata`=0x0, and an accelerator read in the next cycle returns 0x55.
- `rst_n` pulsed low for 1 cycle during an outstanding read:
  - No `rvalid` follows.
  - The clear reruns, and address 9 reads 0 after `init_done`.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the reg_file access controller: FSM states,
// requester ids and the architectural zero address.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_ACC  = 1'b1;

  localparam int unsigned ZERO_ADDR = 0;

endpackage

// File: rtl/rf_wr_arb.sv
// Grant generation for the core/accelerator ports, with round-robin
// resolution of same-address write collisions.
module rf_wr_arb
  import regfile_pkg::*;
#(
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [AWIDTH-1:0] core_addr,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [AWIDTH-1:0] acc_addr,
  output logic              core_gnt,
  output logic              acc_gnt
);

  logic prio_q;
  logic prio_d;
  logic collide;

  always_comb begin
    collide  = en && core_req && core_we && acc_req && acc_we &&
               (core_addr == acc_addr);
    core_gnt = en && core_req && !(collide && (prio_q == REQ_ACC));
    acc_gnt  = en && acc_req  && !(collide && (prio_q == REQ_CORE));
    // Priority moves to whoever lost, so the next collision goes their way.
    prio_d   = prio_q;
    if (collide) begin
      prio_d = ~prio_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= REQ_CORE;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Dual-port reg_file access controller: zero-clears the array after reset,
// then maps core traffic to port A and accelerator traffic to port B.
module regfile_ctrl
  import regfile_pkg::*;
#(
  parameter int DWIDTH   = 64,
  parameter int AWIDTH   = 5,
  parameter int DEPTH    = 2**AWIDTH,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [AWIDTH-1:0] core_addr,
  input  logic [DWIDTH-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DWIDTH-1:0] core_rdata,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [AWIDTH-1:0] acc_addr,
  input  logic [DWIDTH-1:0] acc_wdata,
  output logic              acc_gnt,
  output logic              acc_rvalid,
  output logic [DWIDTH-1:0] acc_rdata,
  output logic              rf_wea,
  output logic [AWIDTH-1:0] rf_addra,
  output logic [DWIDTH-1:0] rf_dina,
  input  logic [DWIDTH-1:0] rf_douta,
  output logic              rf_web,
  output logic [AWIDTH-1:0] rf_addrb,
  output logic [DWIDTH-1:0] rf_dinb,
  input  logic [DWIDTH-1:0] rf_doutb,
  output logic              init_done
);

  localparam int HALF = DEPTH / 2;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              core_rvalid_q, core_rvalid_d;
  logic              acc_rvalid_q, acc_rvalid_d;
  logic              core_zero_q, core_zero_d;
  logic              acc_zero_q, acc_zero_d;
  logic              run_en;
  logic              core_at_zero;
  logic              acc_at_zero;

  assign run_en       = rst_n && (state_q == ST_RUN);
  assign core_at_zero = (ZERO_REG != 0) && (core_addr == AWIDTH'(ZERO_ADDR));
  assign acc_at_zero  = (ZERO_REG != 0) && (acc_addr == AWIDTH'(ZERO_ADDR));

  rf_wr_arb #(.AWIDTH(AWIDTH)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (run_en),
    .core_req  (core_req),
    .core_we   (core_we),
    .core_addr (core_addr),
    .acc_req   (acc_req),
    .acc_we    (acc_we),
    .acc_addr  (acc_addr),
    .core_gnt  (core_gnt),
    .acc_gnt   (acc_gnt)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    init_done_d   = init_done_q;
    rf_wea        = 1'b0;
    rf_web        = 1'b0;
    rf_addra      = core_addr;
    rf_addrb      = acc_addr;
    rf_dina       = core_wdata;
    rf_dinb       = acc_wdata;
    core_rvalid_d = core_gnt && !core_we;
    acc_rvalid_d  = acc_gnt && !acc_we;
    core_zero_d   = core_gnt && !core_we && core_at_zero;
    acc_zero_d    = acc_gnt && !acc_we && acc_at_zero;
    unique case (state_q)
      ST_CLEAR: begin
        // Port A sweeps the lower half, port B the upper half.
        rf_wea   = rst_n;
        rf_web   = rst_n;
        rf_addra = cnt_q;
        rf_addrb = cnt_q + AWIDTH'(HALF);
        rf_dina  = '0;
        rf_dinb  = '0;
        cnt_d    = cnt_q + AWIDTH'(1);
        if (cnt_q == AWIDTH'(HALF - 1)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        rf_wea = core_gnt && core_we && !core_at_zero;
        rf_web = acc_gnt && acc_we && !acc_at_zero;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_CLEAR;
      cnt_q         <= '0;
      init_done_q   <= 1'b0;
      core_rvalid_q <= 1'b0;
      acc_rvalid_q  <= 1'b0;
      core_zero_q   <= 1'b0;
      acc_zero_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      init_done_q   <= init_done_d;
      core_rvalid_q <= core_rvalid_d;
      acc_rvalid_q  <= acc_rvalid_d;
      core_zero_q   <= core_zero_d;
      acc_zero_q    <= acc_zero_d;
    end
  end

  assign init_done   = init_done_q;
  assign core_rvalid = core_rvalid_q;
  assign acc_rvalid  = acc_rvalid_q;
  assign core_rdata  = core_zero_q ? '0 : rf_douta;
  assign acc_rdata   = acc_zero_q ? '0 : rf_doutb;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: a read-first dual-port array model, directed
// scenarios with literal expectations, and randomized traffic vs. a model.
module tb_regfile_ctrl;

  logic        clk;
  logic        rst_n;
  logic        core_req, core_we, acc_req, acc_we;
  logic [4:0]  core_addr, acc_addr;
  logic [63:0] core_wdata, acc_wdata;
  logic        core_gnt, core_rvalid, acc_gnt, acc_rvalid;
  logic [63:0] core_rdata, acc_rdata;
  logic        rf_wea, rf_web;
  logic [4:0]  rf_addra, rf_addrb;
  logic [63:0] rf_dina, rf_dinb, rf_douta, rf_doutb;
  logic        init_done;

  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  regfile_ctrl #(.DWIDTH(64), .AWIDTH(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr),
    .acc_wdata(acc_wdata), .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid),
    .acc_rdata(acc_rdata),
    .rf_wea(rf_wea), .rf_addra(rf_addra), .rf_dina(rf_dina), .rf_douta(rf_douta),
    .rf_web(rf_web), .rf_addrb(rf_addrb), .rf_dinb(rf_dinb), .rf_doutb(rf_doutb),
    .init_done(init_done)
  );

  // Dual-port array with registered, read-first outputs.
  logic [63:0] rf_mem [32];
  always @(posedge clk) begin
    rf_douta <= rf_mem[rf_addra];
    rf_doutb <= rf_mem[rf_addrb];
    if (rf_wea) rf_mem[rf_addra] <= rf_dina;
    if (rf_web) rf_mem[rf_addrb] <= rf_dinb;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_mem [32];
  int          m_clr   = 0;
  bit          m_run   = 0;
  bit          m_prio  = 0;   // 0 = core favoured, 1 = accelerator favoured
  bit          m_valid = 0;
  bit          m_cpend = 0, m_apend = 0;
  logic [63:0] m_cdata = '0, m_adata = '0;

  always @(negedge clk) begin
    bit cg, ag, col;
    if (m_valid) begin
      chk("init_done", init_done, m_run);
      chk("core_rvalid", core_rvalid, m_cpend);
      chk("acc_rvalid", acc_rvalid, m_apend);
      if (m_cpend) chk("core_rdata", core_rdata, m_cdata);
      if (m_apend) chk("acc_rdata", acc_rdata, m_adata);
    end
    if (!rst_n) begin
      if (m_valid) begin
        chk("rst_core_gnt", core_gnt, 0);
        chk("rst_acc_gnt", acc_gnt, 0);
        chk("rst_wea", rf_wea, 0);
        chk("rst_web", rf_web, 0);
      end
      m_clr = 0; m_run = 0; m_prio = 0; m_cpend = 0; m_apend = 0;
      m_valid = 1;
    end else if (m_valid && !m_run) begin
      chk("clr_core_gnt", core_gnt, 0);
      chk("clr_acc_gnt", acc_gnt, 0);
      chk("clr_wea", rf_wea, 1);
      chk("clr_web", rf_web, 1);
      chk("clr_addra", rf_addra, m_clr);
      chk("clr_addrb", rf_addrb, m_clr + 16);
      chk("clr_dina", rf_dina, 0);
      chk("clr_dinb", rf_dinb, 0);
      m_mem[m_clr] = '0;
      m_mem[m_clr + 16] = '0;
      m_clr++;
      if (m_clr == 16) m_run = 1;
      m_cpend = 0; m_apend = 0;
    end else if (m_valid) begin
      col = core_req && core_we && acc_req && acc_we && (core_addr == acc_addr);
      cg  = core_req && !(col && m_prio);
      ag  = acc_req && !(col && !m_prio);
      chk("core_gnt", core_gnt, cg);
      chk("acc_gnt", acc_gnt, ag);
      chk("rf_wea", rf_wea, cg && core_we && core_addr != 0);
      chk("rf_web", rf_web, ag && acc_we && acc_addr != 0);
      if (cg) chk("rf_addra", rf_addra, core_addr);
      if (ag) chk("rf_addrb", rf_addrb, acc_addr);
      if (cg && core_we && core_addr != 0) chk("rf_dina", rf_dina, core_wdata);
      if (ag && acc_we && acc_addr != 0) chk("rf_dinb", rf_dinb, acc_wdata);
      // Reads see the value before this cycle's writes.
      m_cpend = cg && !core_we;
      m_cdata = (core_addr == 0) ? 64'h0 : m_mem[core_addr];
      m_apend = ag && !acc_we;
      m_adata = (acc_addr == 0) ? 64'h0 : m_mem[acc_addr];
      if (cg && core_we && core_addr != 0) m_mem[core_addr] = core_wdata;
      if (ag && acc_we && acc_addr != 0) m_mem[acc_addr] = acc_wdata;
      if (col) m_prio = !m_prio;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [4:0] caddr,
                       input logic [63:0] cwd, input logic areq, input logic awe,
                       input logic [4:0] aaddr, input logic [63:0] awd);
    core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
    acc_req = areq; acc_we = awe; acc_addr = aaddr; acc_wdata = awd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wea_cnt;
    int first_init;
    int gnt_bad;
    int w;
    rst_n = 1'b0;
    idle();
    repeat (3) step();

    // Clear sweep with a core read held throughout.
    rst_n = 1'b1;
    drive(1, 0, 3, 0, 0, 0, 0, 0);
    wea_cnt = 0; first_init = -1; gnt_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rf_wea && rf_web) wea_cnt++;
      if (init_done && first_init < 0) first_init = i;
      if (!init_done && core_gnt) gnt_bad++;
      step();
    end
    chk("clear_we_cycles", wea_cnt, 16);
    chk("init_done_cycle", first_init, 16);
    chk("gnt_during_clear", gnt_bad, 0);

    // Write then read back.
    drive(1, 1, 5, 64'hDEAD_BEEF, 0, 0, 0, 0);
    @(negedge clk); chk("wr5_gnt", core_gnt, 1); step();
    drive(1, 0, 5, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rd5_gnt", core_gnt, 1); step();
    idle();
    @(negedge clk);
    chk("rd5_rvalid", core_rvalid, 1);
    chk("rd5_rdata", core_rdata, 64'hDEAD_BEEF);
    step();

    // Three back-to-back collisions on address 7.
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 7, 64'h1, 1, 1, 7, 64'h2);
      @(negedge clk);
      chk("col_core_gnt", core_gnt, (k != 1));
      chk("col_acc_gnt", acc_gnt, (k == 1));
      step();
    end
    drive(1, 0, 7, 0, 0, 0, 0, 0);
    @(negedge clk); step();
    idle();
    @(negedge clk);
    chk("rd7_rvalid", core_rvalid, 1);
    chk("rd7_rdata", core_rdata, 64'h1);
    step();
    drive(1, 1, 7, 64'h3, 1, 1, 7, 64'h4);
    @(negedge clk);
    chk("prio_acc_core_gnt", core_gnt, 0);
    chk("prio_acc_acc_gnt", acc_gnt, 1);
    step();

    // Zero register.
    drive(1, 1, 0, 64'hFFFF, 1, 0, 0, 0);
    @(negedge clk);
    chk("x0_wea", rf_wea, 0);
    chk("x0_core_gnt", core_gnt, 1);
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("x0_acc_rvalid", acc_rvalid, 1);
    chk("x0_acc_rdata", acc_rdata, 0);
    step();
    idle();
    @(negedge clk);
    chk("x0_core_rvalid", core_rvalid, 1);
    chk("x0_core_rdata", core_rdata, 0);
    step();

    // Same-address read/write on opposite ports is read-first.
    drive(1, 1, 9, 64'h55, 1, 0, 9, 0);
    @(negedge clk); chk("rw9_acc_gnt", acc_gnt, 1); step();
    drive(0, 0, 0, 0, 1, 0, 9, 0);
    @(negedge clk);
    chk("rw9_old_rvalid", acc_rvalid, 1);
    chk("rw9_old_rdata", acc_rdata, 0);
    step();
    idle();
    @(negedge clk);
    chk("rw9_new_rdata", acc_rdata, 64'h55);
    step();

    // Reset pulse right behind an outstanding read.
    drive(1, 0, 9, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rst_rd_gnt", core_gnt, 1); step();
    rst_n = 1'b0;
    @(negedge clk); chk("rst_forced_gnt", core_gnt, 0); step();
    rst_n = 1'b1;
    idle();
    @(negedge clk); chk("rst_no_rvalid", core_rvalid, 0); step();
    for (w = 0; w < 40; w++) begin
      @(negedge clk);
      if (init_done) break;
      step();
    end
    chk("reinit_done", init_done, 1);
    step();
    drive(1, 0, 9, 0, 0, 0, 0, 0);
    @(negedge clk); step();
    idle();
    @(negedge clk);
    chk("rd9_after_rst_rvalid", core_rvalid, 1);
    chk("rd9_after_rst_rdata", core_rdata, 0);
    step();

    // Randomized traffic, narrow address window to force collisions.
    for (int n = 0; n < 3000; n++) begin
      rst_n      = ($urandom_range(0, 599) != 0);
      core_req   = ($urandom_range(0, 3) != 0);
      core_we    = $urandom_range(0, 1);
      core_addr  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      core_wdata = {$urandom, $urandom};
      acc_req    = ($urandom_range(0, 3) != 0);
      acc_we     = $urandom_range(0, 1);
      acc_addr   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      acc_wdata  = {$urandom, $urandom};
      step();
    end
    rst_n = 1'b1;
    idle();
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
